// File: rtl/chu_gpi_irq_pkg.sv
// Register offsets for the debounced GPI slot core.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package chu_gpi_irq_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_DATA  = 5'd0;  // debounced stable value
    localparam logic [ADDR_W-1:0] REG_RAW   = 5'd1;  // synchronised, pre-debounce value
    localparam logic [ADDR_W-1:0] REG_CAPT  = 5'd2;  // sticky edge flags, write-1-to-clear
    localparam logic [ADDR_W-1:0] REG_MASK  = 5'd3;  // interrupt enable
    localparam logic [ADDR_W-1:0] REG_RISE  = 5'd4;  // rising-edge capture enable
    localparam logic [ADDR_W-1:0] REG_FALL  = 5'd5;  // falling-edge capture enable
    localparam logic [ADDR_W-1:0] REG_DBLIM = 5'd6;  // debounce limit

endpackage

// File: rtl/chu_debounce_ch.sv
// One GPI channel: 2-FF synchroniser, debounce counter, stable flop, edge pulses.
// Latency: pin to stable = 2 + limit + 1 cycles; edge pulse coincides with the stable update.
// Backpressure: none; free-running every cycle.
module chu_debounce_ch #(
    parameter int DB_W = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din,
    input  logic [DB_W-1:0] limit,
    output logic            sync,
    output logic            stable,
    output logic            rise,
    output logic            fall
);

    logic            meta_q;
    logic            sync_q;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    // Debounce: stable follows sync only after limit+1 consecutive differing cycles.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_q == stable_q) begin
            // Agreement (including a glitch ending) restarts the count.
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            // >= rather than == so a lowered limit takes effect immediately.
            stable_d = sync_q;
            cnt_d    = '0;
            rise_d   = sync_q;
            fall_d   = ~sync_q;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    // Debounce state and edge pulses; pulses are registered with the stable update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sync   = sync_q;
    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/chu_gpi_irq.sv
// MMIO GPI slot: W debounced inputs, sticky edge capture (W1C), masked level irq.
// Latency: writes land on the next clk edge; rd_data and irq are combinational from flops.
// Backpressure: none; slot bus accepts every access in a single cycle.
module chu_gpi_irq #(
    parameter int W          = 8,
    parameter int DB_W       = 20,
    parameter int DB_DEFAULT = 500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    output logic [31:0]   rd_data,
    input  logic [31:0]   wr_data,
    input  logic [W-1:0]  din,
    output logic          irq
);

    import chu_gpi_irq_pkg::*;

    localparam logic [DB_W-1:0] DBLIM_RST = DB_W'(DB_DEFAULT);

    logic            wr_en;
    logic [W-1:0]    wr_bits;

    logic [W-1:0]    sync_w;
    logic [W-1:0]    stable_w;
    logic [W-1:0]    rise_w;
    logic [W-1:0]    fall_w;
    logic [W-1:0]    capt_set;
    logic [W-1:0]    capt_clr;

    logic [W-1:0]    capt_q,  capt_d;
    logic [W-1:0]    mask_q,  mask_d;
    logic [W-1:0]    rise_en_q, rise_en_d;
    logic [W-1:0]    fall_en_q, fall_en_d;
    logic [DB_W-1:0] dblim_q, dblim_d;

    // Reads have no side effects, and upper write bits are don't-care.
    logic unused_ok;
    assign unused_ok = ^{read, wr_data};

    assign wr_en   = cs & write;
    assign wr_bits = wr_data[W-1:0];

    // One debounce channel per input pin, all sharing the same limit.
    for (genvar i = 0; i < W; i++) begin : g_ch
        chu_debounce_ch #(
            .DB_W (DB_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .din    (din[i]),
            .limit  (dblim_q),
            .sync   (sync_w[i]),
            .stable (stable_w[i]),
            .rise   (rise_w[i]),
            .fall   (fall_w[i])
        );
    end

    assign capt_set = (rise_w & rise_en_q) | (fall_w & fall_en_q);
    assign capt_clr = (wr_en && addr == REG_CAPT) ? wr_bits : '0;

    // Register next-state: plain RW writes, and W1C on CAPT where a new edge beats the clear.
    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        dblim_d   = dblim_q;
        capt_d    = (capt_q & ~capt_clr) | capt_set;
        if (wr_en) begin
            case (addr)
                REG_MASK:  mask_d    = wr_bits;
                REG_RISE:  rise_en_d = wr_bits;
                REG_FALL:  fall_en_d = wr_bits;
                REG_DBLIM: dblim_d   = wr_data[DB_W-1:0];
                default:   ;
            endcase
        end
    end

    // Control and status register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capt_q    <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            dblim_q   <= DBLIM_RST;
        end else begin
            capt_q    <= capt_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            dblim_q   <= dblim_d;
        end
    end

    // Read mux: pure function of addr, zero-extended; chip-select gating is upstream.
    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA:  rd_data[W-1:0]    = stable_w;
            REG_RAW:   rd_data[W-1:0]    = sync_w;
            REG_CAPT:  rd_data[W-1:0]    = capt_q;
            REG_MASK:  rd_data[W-1:0]    = mask_q;
            REG_RISE:  rd_data[W-1:0]    = rise_en_q;
            REG_FALL:  rd_data[W-1:0]    = fall_en_q;
            REG_DBLIM: rd_data[DB_W-1:0] = dblim_q;
            default:   ;
        endcase
    end

    assign irq = |(capt_q & mask_q);

endmodule
